hilo_mult: RTL and testbench

HILO_MULT -- requirements
Module: hilo_mult

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_shift_add.sv | 44 ++++
 rtl/hilo_mult.sv | 126 ++++++++++++
 tb/tb_hilo_mult.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO shift-add multiplier: FSM state type and default width.
package mult_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StAcc,
    StDone
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Product register and one radix-2 shift-add step; the multiplicand is latched alongside P.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] p,
  output logic [2*XLEN-1:0] p_next
);

  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] p_q;
  logic [XLEN:0]     sum;

  // Upper half plus multiplicand, one bit wider so the carry survives the shift.
  always_comb begin
    sum = {1'b0, p_q[2*XLEN-1:XLEN]};
    if (p_q[0]) begin
      sum = sum + {1'b0, a_q};
    end
    p_next = {sum, p_q[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      p_q <= '0;
    end else if (load) begin
      a_q <= a;
      p_q <= {{XLEN{1'b0}}, b};
    end else if (step) begin
      p_q <= p_next;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/hilo_mult.sv
// Iterative unsigned multiplier owning the architectural HI/LO registers.
// Define HILO_MULT_MADDU_EN to honour maddu (accumulate into HI:LO via the ACC state).
module hilo_mult
  import mult_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            maddu,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  mult_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] hilo_q, hilo_d;
  logic [2*XLEN-1:0] prod, prod_next;
  logic              load, step, accept, last, use_acc;

  mult_shift_add #(
    .XLEN(XLEN)
  ) u_shift_add (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .a     (a),
    .b     (b),
    .p     (prod),
    .p_next(prod_next)
  );

`ifdef HILO_MULT_MADDU_EN
  logic maddu_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maddu_q <= 1'b0;
    end else if (load) begin
      maddu_q <= maddu;
    end
  end

  assign use_acc = maddu_q;
`else
  logic unused_sig;
  assign unused_sig = maddu ^ (^prod);
  assign use_acc    = 1'b0;
`endif

  assign accept = start && !abort && (state_q == StIdle || state_q == StDone);
  assign last   = (cnt_q == CntW'(XLEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hilo_d  = hilo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            if (use_acc) begin
              state_d = StAcc;
            end else begin
              state_d = StDone;
              hilo_d  = prod_next;
            end
          end
        end
      end
`ifdef HILO_MULT_MADDU_EN
      StAcc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          hilo_d  = hilo_q + prod;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hilo_q  <= hilo_d;
    end
  end

  assign hi   = hilo_q[2*XLEN-1:XLEN];
  assign lo   = hilo_q[XLEN-1:0];
  assign busy = (state_q == StRun) || (state_q == StAcc);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_hilo_mult.sv
// Randomized self-checking bench for hilo_mult against an arithmetic HI:LO model.
module tb_hilo_mult;

  localparam int unsigned XLEN = 32;
`ifdef HILO_MULT_MADDU_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, maddu, abort;
  logic [XLEN-1:0] a, b, hi, lo;
  logic            busy, done;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] model;

  hilo_mult #(
    .XLEN(XLEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .maddu(maddu),
    .abort(abort),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to its done pulse.
  task automatic run_op(input logic [31:0] ra, input logic [31:0] rb, input logic rm,
                        input bit disturb);
    int          n;
    int          lat;
    bit          busy_ok, hold_ok;
    logic [63:0] prev;
    prev  = model;
    lat   = (MaddEn && rm) ? XLEN + 1 : XLEN;
    model = (MaddEn && rm) ? model + 64'(ra) * 64'(rb) : 64'(ra) * 64'(rb);
    start = 1'b1;
    a     = ra;
    b     = rb;
    maddu = rm;
    edge_wait();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    maddu = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    n       = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < XLEN + 8) begin
      start = disturb && (n == 4);
      edge_wait();
      n++;
      if (!done) begin
        if (!busy) busy_ok = 1'b0;
        if ({hi, lo} !== prev) hold_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("busy_held", 64'(busy_ok), 64'd1);
    check("hilo_held", 64'(hold_ok), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("hilo_result", {hi, lo}, model);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    maddu = 1'b0;
    a     = '0;
    b     = '0;
    model = '0;
    #1;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    #2;
    reset = 1'b0;

    // Largest operands; first start lands on the first edge after reset release.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("max_product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    edge_wait();
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_hold", {hi, lo}, model);

`ifdef HILO_MULT_MADDU_EN
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    run_op(32'h2, 32'h3, 1'b1, 1'b0);
    check("maddu_small", {hi, lo}, 64'h0000_0001_0000_0005);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h2, 1'b1, 1'b0);
    check("maddu_all_ones", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(32'h1, 32'h1, 1'b1, 1'b0);
    check("maddu_wrap", {hi, lo}, 64'h0);
`endif

    // Start during RUN must be ignored.
    run_op($urandom, $urandom, 1'b0, 1'b1);

    // Abort mid-RUN: HI/LO untouched, no done pulse.
    start = 1'b1;
    a     = $urandom;
    b     = $urandom;
    maddu = 1'b0;
    edge_wait();
    start = 1'b0;
    for (int k = 1; k < 10; k++) edge_wait();
    abort = 1'b1;
    edge_wait();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, model);
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge_wait();
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_quiet", 64'(saw_done), 64'd0);

    // Abort wins over a simultaneous start while in DONE.
    run_op($urandom, $urandom, 1'($urandom), 1'b0);
    start = 1'b1;
    abort = 1'b1;
    edge_wait();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    check("abort_start_done", 64'(done), 64'd0);
    edge_wait();
    check("abort_start_idle", 64'(busy), 64'd0);

    // Back-to-back random operations, each accepted straight from DONE.
    repeat (16) run_op($urandom, $urandom, 1'($urandom), 1'($urandom));

    // Asynchronous reset between clock edges mid-RUN.
    start = 1'b1;
    a     = $urandom;
    b     = $urandom;
    edge_wait();
    start = 1'b0;
    for (int k = 0; k < 6; k++) edge_wait();
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_hi", 64'(hi), 64'd0);
    check("async_reset_lo", 64'(lo), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    model = '0;
    run_op(32'h2, 32'h3, 1'b1, 1'b0);
    check("post_reset_lo", 64'(lo), 64'd6);
    check("post_reset_hi", 64'(hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
